mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single AXI read/write bridge between three requesters: icache burst read, dcache burst/MMIO read, and dcache write-through.
- Sits between icache/dcache and the AXI master bridge.
- Grants one transaction at a time and holds the grant until its last beat (read) or write-done.
- Routes per-beat ready/data back to the granted requester only.

Parameters:
- ADDR_W, 64, address width.
- DATA_W, 64, data beat width.
- MASK_W, 8, write byte-mask width (DATA_W/8).

Ports:
- cpu_clk_50M  in  1  clock.
- cpu_rst_n  in  1  synchronous active-low reset.
- i_rd_valid  in  1  icache read request.
- i_rd_addr  in  ADDR_W  icache line address.
- i_rd_len  in  2  icache beat count.
- i_rd_size  in  2  icache beat size.
- i_rd_ready  out  1  icache beat strobe.
- i_rd_data  out  DATA_W  icache beat data.
- d_rd_valid  in  1  dcache read request.
- d_rd_addr  in  ADDR_W  dcache read address.
- d_rd_len  in  2  dcache beat count.
- d_rd_size  in  2  dcache beat size.
- d_rd_ready  out  1  dcache beat strobe.
- d_rd_data  out  DATA_W  dcache beat data.
- d_wr_valid  in  1  dcache write request.
- d_wr_addr  in  ADDR_W  write address.
- d_wr_data  in  DATA_W  write data.
- d_wr_mask  in  MASK_W  write byte mask.
- d_wr_done  out  1  write complete pulse.
- bus_valid  out  1  request to bridge.
- bus_is_write  out  1  1=write, 0=read.
- bus_addr  out  ADDR_W  latched address.
- bus_len  out  2  latched beat count.
- bus_size  out  2  latched beat size.
- bus_w_data  out  DATA_W  latched write data.
- bus_w_mask  out  MASK_W  latched write mask.
- bus_rd_ready  in  1  read beat valid from bridge.
- bus_rd_data  in  DATA_W  read beat data.
- bus_w_done  in  1  write response from bridge.

Behaviour:
- Clock and reset: one clock, cpu_clk_50M. Reset is synchronous, active-low, on cpu_rst_n.
- State machine: S_IDLE, S_IREAD, S_DREAD, S_WRITE. Reset gives S_IDLE.
- Reset values: all bus_* outputs 0, beat counter 0, and i/d ready, data and d_wr_done all 0.
- Reset asserted mid-transaction: immediate return to S_IDLE, all state cleared; the bridge is reset in the same cycle.
- Arbitration in S_IDLE, fixed priority: d_wr_valid > d_rd_valid > i_rd_valid.
  - Write first keeps write-through ordering ahead of dcache refills.
  - Losers keep waiting, with no side effects.
- On grant:
  - Address, len, size, data and mask are latched into the bus_* registers.
  - bus_valid rises on the next cycle, giving 1-cycle grant latency.
- bus_valid stays high throughout S_IREAD/S_DREAD/S_WRITE. bus_* fields are stable for the whole transaction.
- Beat count: beats = bus_len, with len 0 treated as 1 (2'b10 = two-beat line refill). A 2-bit counter tracks received beats.
- Read beats:
  - The bus_rd_ready pulse is forwarded combinationally to the granted requester's *_rd_ready; the other requester's ready stays 0.
  - *_rd_data mirrors bus_rd_data while that requester is granted, and is 0 otherwise.
- Last read beat (count == beats-1 with bus_rd_ready): next state S_IDLE, bus_valid 0 and counter 0.
- S_WRITE: wait for bus_w_done. Then d_wr_done pulses 1 cycle (same cycle, combinational), and next state is S_IDLE.
- Requester re-arbitration:
  - Every transaction passes through at least one S_IDLE cycle.
  - A requester holding valid high is re-granted at its priority.
  - The dcache must drop d_wr_valid on d_wr_done, otherwise the write repeats.
- Requester drops valid mid-transaction: ignored. The transaction completes and beats are still strobed.
- Spurious bus_rd_ready in S_IDLE or S_WRITE, or bus_w_done outside S_WRITE: ignored, no output pulse.

Optional Feature:
- Macro RR_READ_ARB_EN.
- Defined:
  - Writes keep absolute priority.
  - Between d_rd and i_rd, a 1-bit last-served register makes the read not served most recently win on simultaneous requests.
  - The register resets to "icache served".
- Undefined: fixed dcache-over-icache read priority, and no extra register.

Decomposition:
- Shared package / defines.v holds:
  - State encodings (S_IDLE..S_WRITE).
  - Size encodings (reuse SIZE_B/H/W/D).
  - TRUE_V/FALSE_V, RST_ENABLE, ZERO_WORD.
- One sub-module, arb_prio_sel: combinational grant selection, including the RR_READ_ARB_EN last-served logic.
- The FSM and latches stay in the top module.

Test Plan:
- Reset mid-S_DREAD after 1 of 2 beats: release reset, then i_rd_valid alone → i granted, and 2 i_rd_ready pulses with no stale d_rd_ready.
- i_rd_valid, addr 0x8000_0010, len 2'b10 → bus_valid the next cycle with bus_addr 0x8000_0010.
  - bus_rd_data 0x11 then 0x22 → i_rd_ready pulses twice with that data; d_rd_ready stays 0.
  - Returns to S_IDLE after beat 2.
- d_wr_valid and d_rd_valid in the same cycle → S_WRITE first with bus_is_write=1 and mask 0xFF.
  - bus_w_done → d_wr_done pulse.
  - One idle cycle, then S_DREAD grant.
- MMIO d_rd_valid, len 2'b01, addr 0x0200_BFF8 → exactly one beat, then S_IDLE.
- i_rd_valid and d_rd_valid both held high for 4 transactions.
  - Without macro → d,d,d,d.
  - With RR_READ_ARB_EN → d,i,d,i.
- bus_rd_ready pulse during S_IDLE → no *_rd_ready, state unchanged.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared states, size codes and constants for the memory port arbiter
package mem_port_arbiter_pkg;
  typedef enum logic [1:0] {S_IDLE, S_IREAD, S_DREAD, S_WRITE} state_e;
  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_D = 2'd3;
  localparam logic TRUE_V = 1'b1;
  localparam logic FALSE_V = 1'b0;
  localparam logic RST_ENABLE = 1'b0;
  localparam logic [63:0] ZERO_WORD = 64'h0;
  // A len of 0 still moves one beat.
  function automatic logic [1:0] beats_of(input logic [1:0] len);
    return len == 2'd0 ? 2'd1 : len;
  endfunction
endpackage

// File: rtl/mem_port_arbiter_arb_prio_sel.sv
// arb_prio_sel: picks the next transaction for the arbiter; write > dcache read > icache read
// Ports: wr_req/d_req/i_req requests in, sel = granted state (S_IDLE when none).
// With RR_READ_ARB_EN defined, clk/rst_n/take add a last-served bit so simultaneous
// reads alternate; take marks cycles where the arbiter is idle and will accept sel.
module arb_prio_sel
  import mem_port_arbiter_pkg::*;
(
`ifdef RR_READ_ARB_EN
  input  logic   clk,
  input  logic   rst_n,
  input  logic   take,
`endif
  input  logic   wr_req,
  input  logic   d_req,
  input  logic   i_req,
  output state_e sel
);
  logic d_wins;
`ifdef RR_READ_ARB_EN
  logic last_d_q, last_d_d;
  always_comb begin
    d_wins = d_req && !(i_req && last_d_q);
    last_d_d = take && !wr_req && (d_req || i_req) ? d_wins : last_d_q;
  end
  always_ff @(posedge clk)
    if (rst_n == RST_ENABLE) last_d_q <= FALSE_V;
    else last_d_q <= last_d_d;
`else
  assign d_wins = d_req;
`endif
  assign sel = wr_req ? S_WRITE : d_wins ? S_DREAD : i_req ? S_IREAD : S_IDLE;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one AXI bridge between icache read, dcache read and dcache write-through
// Ports: i_rd_* icache request/beat return, d_rd_* dcache request/beat return, d_wr_* write
// request with d_wr_done pulse, bus_* latched request to the bridge, bus_rd_ready/bus_rd_data
// read beats and bus_w_done write response from the bridge. cpu_rst_n is synchronous active-low.
// Optional macro RR_READ_ARB_EN: alternate dcache/icache reads on simultaneous requests.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int MASK_W = 8
) (
  input  logic              cpu_clk_50M,
  input  logic              cpu_rst_n,
  input  logic              i_rd_valid,
  input  logic [ADDR_W-1:0] i_rd_addr,
  input  logic [1:0]        i_rd_len,
  input  logic [1:0]        i_rd_size,
  output logic              i_rd_ready,
  output logic [DATA_W-1:0] i_rd_data,
  input  logic              d_rd_valid,
  input  logic [ADDR_W-1:0] d_rd_addr,
  input  logic [1:0]        d_rd_len,
  input  logic [1:0]        d_rd_size,
  output logic              d_rd_ready,
  output logic [DATA_W-1:0] d_rd_data,
  input  logic              d_wr_valid,
  input  logic [ADDR_W-1:0] d_wr_addr,
  input  logic [DATA_W-1:0] d_wr_data,
  input  logic [MASK_W-1:0] d_wr_mask,
  output logic              d_wr_done,
  output logic              bus_valid,
  output logic              bus_is_write,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [1:0]        bus_len,
  output logic [1:0]        bus_size,
  output logic [DATA_W-1:0] bus_w_data,
  output logic [MASK_W-1:0] bus_w_mask,
  input  logic              bus_rd_ready,
  input  logic [DATA_W-1:0] bus_rd_data,
  input  logic              bus_w_done
);
  state_e state_q, state_d, sel;
  logic [1:0] cnt_q, cnt_d, len_q, len_d, size_q, size_d;
  logic valid_q, valid_d, is_write_q, is_write_d, last_beat;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [MASK_W-1:0] mask_q, mask_d;

  arb_prio_sel u_sel (
`ifdef RR_READ_ARB_EN
    .clk(cpu_clk_50M),
    .rst_n(cpu_rst_n),
    .take(state_q == S_IDLE),
`endif
    .wr_req(d_wr_valid),
    .d_req(d_rd_valid),
    .i_req(i_rd_valid),
    .sel(sel)
  );

  always_comb begin
    last_beat = bus_rd_ready && cnt_q == beats_of(len_q) - 2'd1;
    state_d = state_q;
    cnt_d = cnt_q;
    valid_d = valid_q;
    is_write_d = is_write_q;
    addr_d = addr_q;
    len_d = len_q;
    size_d = size_q;
    wdata_d = wdata_q;
    mask_d = mask_q;
    case (state_q)
      S_IDLE: if (sel != S_IDLE) begin
        state_d = sel;
        valid_d = TRUE_V;
        cnt_d = '0;
        is_write_d = sel == S_WRITE;
        addr_d = sel == S_WRITE ? d_wr_addr : sel == S_DREAD ? d_rd_addr : i_rd_addr;
        len_d = sel == S_WRITE ? 2'd0 : sel == S_DREAD ? d_rd_len : i_rd_len;
        size_d = sel == S_WRITE ? SIZE_D : sel == S_DREAD ? d_rd_size : i_rd_size;
        wdata_d = sel == S_WRITE ? d_wr_data : '0;
        mask_d = sel == S_WRITE ? d_wr_mask : '0;
      end
      S_WRITE: if (bus_w_done) begin
        state_d = S_IDLE;
        valid_d = FALSE_V;
      end
      default: if (bus_rd_ready) begin
        state_d = last_beat ? S_IDLE : state_q;
        valid_d = !last_beat;
        cnt_d = last_beat ? 2'd0 : cnt_q + 2'd1;
      end
    endcase
  end

  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst_n == RST_ENABLE) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      valid_q <= FALSE_V;
      is_write_q <= FALSE_V;
      addr_q <= '0;
      len_q <= '0;
      size_q <= '0;
      wdata_q <= '0;
      mask_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      valid_q <= valid_d;
      is_write_q <= is_write_d;
      addr_q <= addr_d;
      len_q <= len_d;
      size_q <= size_d;
      wdata_q <= wdata_d;
      mask_q <= mask_d;
    end
  end

  // Beat strobes and data reach only the granted requester.
  assign i_rd_ready = state_q == S_IREAD && bus_rd_ready;
  assign d_rd_ready = state_q == S_DREAD && bus_rd_ready;
  assign i_rd_data = state_q == S_IREAD ? bus_rd_data : '0;
  assign d_rd_data = state_q == S_DREAD ? bus_rd_data : '0;
  assign d_wr_done = state_q == S_WRITE && bus_w_done;
  assign bus_valid = valid_q;
  assign bus_is_write = is_write_q;
  assign bus_addr = addr_q;
  assign bus_len = len_q;
  assign bus_size = size_q;
  assign bus_w_data = wdata_q;
  assign bus_w_mask = mask_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table, corner sequences and randomized reference-model check
module tb_mem_port_arbiter;
  logic cpu_clk_50M = 1'b0;
  logic cpu_rst_n;
  logic i_rd_valid, d_rd_valid, d_wr_valid, bus_rd_ready, bus_w_done;
  logic [63:0] i_rd_addr, d_rd_addr, d_wr_addr, d_wr_data, bus_rd_data;
  logic [1:0] i_rd_len, i_rd_size, d_rd_len, d_rd_size;
  logic [7:0] d_wr_mask;
  logic i_rd_ready, d_rd_ready, d_wr_done, bus_valid, bus_is_write;
  logic [63:0] i_rd_data, d_rd_data, bus_addr, bus_w_data;
  logic [1:0] bus_len, bus_size;
  logic [7:0] bus_w_mask;

  mem_port_arbiter dut (
    .cpu_clk_50M(cpu_clk_50M), .cpu_rst_n(cpu_rst_n),
    .i_rd_valid(i_rd_valid), .i_rd_addr(i_rd_addr), .i_rd_len(i_rd_len), .i_rd_size(i_rd_size),
    .i_rd_ready(i_rd_ready), .i_rd_data(i_rd_data),
    .d_rd_valid(d_rd_valid), .d_rd_addr(d_rd_addr), .d_rd_len(d_rd_len), .d_rd_size(d_rd_size),
    .d_rd_ready(d_rd_ready), .d_rd_data(d_rd_data),
    .d_wr_valid(d_wr_valid), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data), .d_wr_mask(d_wr_mask),
    .d_wr_done(d_wr_done),
    .bus_valid(bus_valid), .bus_is_write(bus_is_write), .bus_addr(bus_addr), .bus_len(bus_len),
    .bus_size(bus_size), .bus_w_data(bus_w_data), .bus_w_mask(bus_w_mask),
    .bus_rd_ready(bus_rd_ready), .bus_rd_data(bus_rd_data), .bus_w_done(bus_w_done)
  );

  always #10 cpu_clk_50M = ~cpu_clk_50M;

  localparam logic [63:0] IA = 64'h0000_0000_8000_0010;
  localparam logic [63:0] DA = 64'h0000_0000_0200_BFF8;
  localparam logic [63:0] WA = 64'h0000_0000_1000_0040;
  localparam logic [63:0] WD = 64'hDEAD_BEEF_0123_4567;

  typedef struct {
    logic [5:0]  ctl;
    logic [7:0]  rd;
    logic [1:0]  bus;
    logic [63:0] addr;
    logic [1:0]  len;
    logic [7:0]  msk;
    logic [2:0]  rsp;
    logic [7:0]  id;
    logic [7:0]  dd;
  } vec_t;

  vec_t vt[13];
  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge cpu_clk_50M);
    #1;
  endtask

  task automatic idle_inputs();
    i_rd_valid = 0; d_rd_valid = 0; d_wr_valid = 0; bus_rd_ready = 0; bus_w_done = 0;
    bus_rd_data = '0;
  endtask

  int own, left;
  bit last_d;
  logic m_w;
  logic [63:0] m_addr, m_wd;
  logic [1:0] m_len, m_size;
  logic [7:0] m_msk;

  task automatic model_reset();
    own = 0; left = 0; last_d = 0; m_w = 0; m_addr = 0; m_wd = 0; m_len = 0; m_size = 0; m_msk = 0;
  endtask

  task automatic model_step();
    int w;
    if (!cpu_rst_n) begin
      model_reset();
      return;
    end
    if (own == 0) begin
      w = 0;
      if (d_wr_valid) w = 3;
      else if (d_rd_valid && i_rd_valid) begin
`ifdef RR_READ_ARB_EN
        w = last_d ? 1 : 2;
`else
        w = 2;
`endif
      end
      else if (d_rd_valid) w = 2;
      else if (i_rd_valid) w = 1;
      if (w == 3) begin
        own = 3; m_w = 1; m_addr = d_wr_addr; m_len = 0; m_size = 2'd3; m_wd = d_wr_data; m_msk = d_wr_mask;
      end else if (w != 0) begin
        own = w; m_w = 0; m_wd = 0; m_msk = 0; last_d = (w == 2);
        m_addr = w == 2 ? d_rd_addr : i_rd_addr;
        m_len = w == 2 ? d_rd_len : i_rd_len;
        m_size = w == 2 ? d_rd_size : i_rd_size;
        left = m_len == 0 ? 1 : int'(m_len);
      end
    end else if (own == 3) begin
      if (bus_w_done) own = 0;
    end else if (bus_rd_ready) begin
      left--;
      if (left == 0) own = 0;
    end
  endtask

  initial begin
    logic [7:0] got[4];
    logic [7:0] want[4];
    int n;
    logic prev_v;
    vt[0]  = '{6'b100000, 8'h00, 2'b00, 64'h0, 2'd0, 8'h00, 3'b000, 8'h00, 8'h00};
    vt[1]  = '{6'b110000, 8'h00, 2'b00, 64'h0, 2'd0, 8'h00, 3'b000, 8'h00, 8'h00};
    vt[2]  = '{6'b100010, 8'h11, 2'b10, IA,    2'd2, 8'h00, 3'b100, 8'h11, 8'h00};
    vt[3]  = '{6'b100010, 8'h22, 2'b10, IA,    2'd2, 8'h00, 3'b100, 8'h22, 8'h00};
    vt[4]  = '{6'b100000, 8'h00, 2'b00, IA,    2'd2, 8'h00, 3'b000, 8'h00, 8'h00};
    vt[5]  = '{6'b100010, 8'h33, 2'b00, IA,    2'd2, 8'h00, 3'b000, 8'h00, 8'h00};
    vt[6]  = '{6'b100001, 8'h00, 2'b00, IA,    2'd2, 8'h00, 3'b000, 8'h00, 8'h00};
    vt[7]  = '{6'b101100, 8'h00, 2'b00, IA,    2'd2, 8'h00, 3'b000, 8'h00, 8'h00};
    vt[8]  = '{6'b101110, 8'h55, 2'b11, WA,    2'd0, 8'hFF, 3'b000, 8'h00, 8'h00};
    vt[9]  = '{6'b101101, 8'h00, 2'b11, WA,    2'd0, 8'hFF, 3'b001, 8'h00, 8'h00};
    vt[10] = '{6'b101000, 8'h00, 2'b01, WA,    2'd0, 8'hFF, 3'b000, 8'h00, 8'h00};
    vt[11] = '{6'b101010, 8'h44, 2'b10, DA,    2'd1, 8'h00, 3'b010, 8'h00, 8'h44};
    vt[12] = '{6'b100001, 8'h00, 2'b00, DA,    2'd1, 8'h00, 3'b000, 8'h00, 8'h00};

    i_rd_addr = IA; i_rd_len = 2'd2; i_rd_size = 2'd3;
    d_rd_addr = DA; d_rd_len = 2'd1; d_rd_size = 2'd2;
    d_wr_addr = WA; d_wr_data = WD; d_wr_mask = 8'hFF;
    idle_inputs();
    cpu_rst_n = 0;
    #1;
    cyc(); cyc();

    for (int i = 0; i < 13; i++) begin
      {cpu_rst_n, i_rd_valid, d_rd_valid, d_wr_valid, bus_rd_ready, bus_w_done} = vt[i].ctl;
      bus_rd_data = {56'h0, vt[i].rd};
      #5;
      chk($sformatf("vec%0d", i),
          256'({bus_valid, bus_is_write, bus_addr, bus_len, bus_w_mask, i_rd_ready, d_rd_ready, d_wr_done, i_rd_data, d_rd_data}),
          256'({vt[i].bus, vt[i].addr, vt[i].len, vt[i].msk, vt[i].rsp, 56'h0, vt[i].id, 56'h0, vt[i].dd}));
      cyc();
    end

    idle_inputs();
    cpu_rst_n = 1;
    d_rd_len = 2'd2;
    d_rd_valid = 1;
    cyc();
    d_rd_valid = 0; bus_rd_ready = 1; bus_rd_data = 64'h66;
    #5;
    chk("rst_seq_dbeat1", 256'({d_rd_ready, d_rd_data, bus_valid}), 256'({1'b1, 64'h66, 1'b1}));
    cyc();
    bus_rd_ready = 0; cpu_rst_n = 0;
    cyc();
    cpu_rst_n = 1;
    #5;
    chk("rst_seq_cleared", 256'({bus_valid, bus_is_write, bus_addr, bus_len, bus_w_mask}), 256'(0));
    i_rd_valid = 1;
    cyc();
    i_rd_valid = 0; bus_rd_ready = 1; bus_rd_data = 64'h77;
    #5;
    chk("rst_seq_ibeat1", 256'({i_rd_ready, d_rd_ready, i_rd_data, bus_addr}), 256'({1'b1, 1'b0, 64'h77, IA}));
    cyc();
    bus_rd_data = 64'h88;
    #5;
    chk("rst_seq_ibeat2", 256'({i_rd_ready, d_rd_ready, i_rd_data}), 256'({1'b1, 1'b0, 64'h88}));
    cyc();
    bus_rd_ready = 0;
    #5;
    chk("rst_seq_done", 256'({bus_valid, i_rd_ready, d_rd_ready}), 256'(0));

    cpu_rst_n = 0;
    cyc();
    cpu_rst_n = 1; d_rd_len = 2'd1;
    i_rd_valid = 1; d_rd_valid = 1; bus_rd_ready = 1; bus_rd_data = 64'h99;
    n = 0; prev_v = 0;
    for (int c = 0; c < 60 && n < 4; c++) begin
      #5;
      if (bus_valid && !prev_v) begin
        got[n] = d_rd_ready ? "d" : i_rd_ready ? "i" : "?";
        n++;
      end
      prev_v = bus_valid;
      cyc();
    end
`ifdef RR_READ_ARB_EN
    want[0] = "d"; want[1] = "i"; want[2] = "d"; want[3] = "i";
`else
    want[0] = "d"; want[1] = "d"; want[2] = "d"; want[3] = "d";
`endif
    chk("rr_txn_count", 256'(n), 256'(4));
    for (int k = 0; k < n; k++) chk($sformatf("rr_grant%0d", k), 256'(got[k]), 256'(want[k]));

    idle_inputs();
    cpu_rst_n = 0;
    cyc();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      cpu_rst_n = $urandom_range(0, 99) >= 2;
      i_rd_valid = $urandom_range(0, 99) < 40;
      d_rd_valid = $urandom_range(0, 99) < 40;
      d_wr_valid = $urandom_range(0, 99) < 25;
      i_rd_addr = {$urandom, $urandom}; d_rd_addr = {$urandom, $urandom}; d_wr_addr = {$urandom, $urandom};
      d_wr_data = {$urandom, $urandom}; d_wr_mask = 8'($urandom);
      i_rd_len = 2'($urandom_range(0, 3)); d_rd_len = 2'($urandom_range(0, 3));
      i_rd_size = 2'($urandom_range(0, 3)); d_rd_size = 2'($urandom_range(0, 3));
      bus_rd_ready = $urandom_range(0, 99) < 50;
      bus_w_done = $urandom_range(0, 99) < 30;
      bus_rd_data = {$urandom, $urandom};
      #5;
      chk($sformatf("rand_bus%0d", c),
          256'({bus_valid, bus_is_write, bus_addr, bus_len, bus_size, bus_w_data, bus_w_mask}),
          256'({own != 0, m_w, m_addr, m_len, m_size, m_wd, m_msk}));
      chk($sformatf("rand_rsp%0d", c),
          256'({i_rd_ready, d_rd_ready, d_wr_done, i_rd_data, d_rd_data}),
          256'({own == 1 && bus_rd_ready, own == 2 && bus_rd_ready, own == 3 && bus_w_done,
                own == 1 ? bus_rd_data : 64'h0, own == 2 ? bus_rd_data : 64'h0}));
      model_step();
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
